instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 25 ++
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// framing constants and the header length check.
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    // Length header is two bytes, little-endian word count
    localparam int HEADER_BYTES   = 2;
    // Program bytes packed into each 32-bit instruction word
    localparam int BYTES_PER_WORD = 4;

    // A header is usable only if it names at least one word and fits in memory
    function automatic logic len_ok(input logic [15:0] len, input int max_words);
        return (len != 16'd0) && (int'(len) <= max_words);
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed program from a byte interface into the
// instruction memory write port, holding the core while the load runs.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int WordQuantity = 256,
    parameter int BitSize      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    loader_state_t      state;
    loader_state_t      state_next;
    logic [15:0]        count;
    logic [BitSize:0]   word_idx;
    logic [1:0]         byte_cnt;
    logic [23:0]        wdata_buf;
    logic [15:0]        len_full;
    logic               last_word;

    // The high length byte is combined with the stored low byte as it arrives
    assign len_full  = {byte_in, count[7:0]};
    // The word being written now is the final one when its successor index equals the count
    assign last_word = ((32'(word_idx) + 32'd1) == {16'd0, count});

    // State register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Next-state decode and state-derived handshake/status outputs
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_hold = 1'b0;
                if (start) state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (len_ok(len_full, WordQuantity)) state_next = ST_DATA;
                    else                                state_next = ST_ERROR;
                end
            end
            ST_DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1))) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                // A reset landing on this edge must not let the memory commit the word
                mem_we = rst;
                if (last_word) state_next = ST_DONE;
                else           state_next = ST_DATA;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_next = ST_LEN_LO;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) state_next = ST_LEN_LO;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Length capture, byte packing, word counting and the registered write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= 16'd0;
            word_idx  <= '0;
            byte_cnt  <= 2'd0;
            wdata_buf <= 24'd0;
            mem_waddr <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        count     <= 16'd0;
                        word_idx  <= '0;
                        byte_cnt  <= 2'd0;
                        wdata_buf <= 24'd0;
                    end
                end
                ST_LEN_LO: begin
                    if (byte_valid) count[7:0] <= byte_in;
                end
                ST_LEN_HI: begin
                    if (byte_valid) count[15:8] <= byte_in;
                end
                ST_DATA: begin
                    if (byte_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: wdata_buf[7:0]   <= byte_in;
                            2'd1: wdata_buf[15:8]  <= byte_in;
                            2'd2: wdata_buf[23:16] <= byte_in;
                            default: begin
                                mem_waddr <= 32'(word_idx) << 2;
                                mem_wdata <= {byte_in, wdata_buf};
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_idx + {{BitSize{1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader: the stimulus side
// predicts every memory write, an independent monitor pops and compares.
module tb_instr_mem_loader;

    localparam int WORDS = 256;
    localparam int BITS  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int mode  = 0;
    logic toggle_phase = 1'b0;

    logic [63:0] exp_q[$];
    logic [7:0]  payload[$];

    instr_mem_loader #(
        .WordQuantity(WORDS),
        .BitSize(BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we(mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Free-running cycle count used for latency checks
    always @(posedge clk) cycle <= cycle + 1;

    // Hang guard
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        #2;
        if (mem_we === 1'b1) begin
            check_output("write_ready_low", {31'd0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h required no write",
                         mem_waddr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check_output("write_addr", mem_waddr, e[63:32]);
                check_output("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check_output({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        check_output({tag, "_mem_waddr"},  mem_waddr,           32'd0);
        check_output({tag, "_mem_wdata"},  mem_wdata,           32'd0);
        check_output({tag, "_done"},       {31'd0, done},       32'd0);
        check_output({tag, "_error"},      {31'd0, error},      32'd0);
        check_output({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
    endtask

    task automatic fill_payload(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    // Offer one byte until accepted; the valid pattern depends on the mode
    task automatic apply_stimulus(input logic [7:0] b, output int acc_cycle);
        logic acc;
        logic valid_now;
        int   guard;
        acc = 1'b0;
        guard = 0;
        acc_cycle = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            guard++;
            case (mode)
                0: valid_now = 1'b1;
                1: begin
                    toggle_phase = ~toggle_phase;
                    valid_now = toggle_phase;
                end
                default: valid_now = ($urandom_range(0, 9) < 7);
            endcase
            start = (mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
            if (valid_now) begin
                byte_valid = 1'b1;
                byte_in    = b;
                acc        = byte_ready;
                acc_cycle  = cycle;
            end else begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL byte_accept_timeout: got byte_ready 0 required 1");
        end
    endtask

    // One complete load: header, payload, and the predicted outcome
    task automatic run_load(input logic [15:0] len, input int m);
        int   c0;
        int   c;
        int   guard;
        int   done_cycle;
        logic len_good;
        logic [31:0] last_addr;
        logic [31:0] last_data;
        mode = m;
        len_good = (len != 16'd0) && (int'(len) <= WORDS);
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_output("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check_output("start_done_clr", {31'd0, done}, 32'd0);
        check_output("start_error_clr", {31'd0, error}, 32'd0);
        last_addr = 32'd0;
        last_data = 32'd0;
        if (len_good) begin
            for (int i = 0; i < int'(len); i++) begin
                last_addr = 32'(i * 4);
                last_data = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
                exp_q.push_back({last_addr, last_data});
            end
        end
        apply_stimulus(len[7:0], c0);
        apply_stimulus(len[15:8], c);
        if (!len_good) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start = 1'b0;
            #1;
            check_output("hdr_error", {31'd0, error}, 32'd1);
            check_output("hdr_error_hold", {31'd0, cpu_hold}, 32'd1);
            check_output("hdr_error_done", {31'd0, done}, 32'd0);
            check_output("hdr_error_ready", {31'd0, byte_ready}, 32'd0);
            repeat (4) @(negedge clk);
            #1;
            check_output("hdr_error_stays", {31'd0, error}, 32'd1);
            return;
        end
        for (int i = 0; i < 4 * int'(len); i++) apply_stimulus(payload[i], c);
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
        #1;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        done_cycle = cycle;
        check_output("load_done", {31'd0, done}, 32'd1);
        check_output("load_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check_output("load_error", {31'd0, error}, 32'd0);
        check_output("load_pending_writes", 32'(exp_q.size()), 32'd0);
        check_output("hold_waddr", mem_waddr, last_addr);
        check_output("hold_wdata", mem_wdata, last_data);
        if (m == 0) check_output("throughput_cycles", 32'(done_cycle - c0), 32'(2 + 5 * int'(len)));
    endtask

    initial begin
        int c;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // Two-word reference program with a continuous stream
        payload.delete();
        payload = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        run_load(16'h0002, 0);

        // Zero-length header rejected, then a good load clears the error
        payload.delete();
        run_load(16'h0000, 0);
        fill_payload(4);
        run_load(16'h0001, 2);

        // Oversize header rejected
        run_load(16'h0101, 0);

        // Full memory, random valid gaps and spurious start pulses
        fill_payload(4 * WORDS);
        run_load(16'h0100, 2);

        // Toggling valid gives the same words as a continuous stream
        payload = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        run_load(16'h0002, 1);
        fill_payload(20);
        run_load(16'h0005, 1);

        // Assorted random loads
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_payload(4 * n);
            run_load(16'(n), $urandom_range(0, 2));
        end

        // Reset after the sixth data byte aborts the load
        mode = 0;
        fill_payload(16);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back({32'd0, payload[3], payload[2], payload[1], payload[0]});
        apply_stimulus(8'h04, c);
        apply_stimulus(8'h00, c);
        for (int i = 0; i < 6; i++) apply_stimulus(payload[i], c);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("midload_reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_output("midload_pending", 32'(exp_q.size()), 32'd0);
        check_output("midload_idle_hold", {31'd0, cpu_hold}, 32'd0);

        // Reset landing on the write cycle must suppress the write
        fill_payload(8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        apply_stimulus(8'h02, c);
        apply_stimulus(8'h00, c);
        for (int i = 0; i < 4; i++) apply_stimulus(payload[i], c);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("write_reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // A final clean load after the aborted ones
        fill_payload(12);
        run_load(16'h0003, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
